// File: rtl/mlp_pkg.sv
// ============================================================================
// Module   : mlp_pkg
// Brief    : Shared widths, fixed-point types and per-term flags for the MLP MAC
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mlp_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int ACC_W     = 40;
    localparam int NADDR_W   = 12;
    localparam int WADDR_W   = 16;

    typedef logic signed [DATA_W-1:0]   data_t;
    typedef logic signed [2*DATA_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]    acc_t;
    typedef logic [NADDR_W-1:0]         naddr_t;
    typedef logic [WADDR_W-1:0]         waddr_t;

    typedef struct packed {
        logic   last;
        logic   clr;
        naddr_t waddr;
    } term_flags_t;

endpackage

`default_nettype wire

// File: rtl/mlp_round_sat.sv
// ============================================================================
// Module   : mlp_round_sat
// Brief    : Accumulator -> neuron format: round-half-up, shift, saturate,
//            optional ReLU when MLP_RELU_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mlp_round_sat
    import mlp_pkg::*;
(
    input  logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] result
);

    localparam logic signed [ACC_W:0] C_HALF =
        {{(ACC_W+1-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
    localparam logic signed [ACC_W:0] C_MAX =
        {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] C_MIN = ~C_MAX;

    // One guard bit so the rounding increment can never wrap
    logic signed [ACC_W:0] w_sum;
    logic signed [ACC_W:0] w_shift;

    assign w_sum   = $signed({acc[ACC_W-1], acc}) + C_HALF;
    assign w_shift = w_sum >>> FRAC_BITS;

    always_comb begin
        if (w_shift > C_MAX) begin
            result = C_MAX[DATA_W-1:0];
        end else if (w_shift < C_MIN) begin
            result = C_MIN[DATA_W-1:0];
        end else begin
            result = w_shift[DATA_W-1:0];
        end
`ifdef MLP_RELU_EN
        if (w_shift[ACC_W]) begin
            result = '0;
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/mlp_mac_datapath.sv
// ============================================================================
// Module   : mlp_mac_datapath
// Brief    : 4-stage neuron MAC pipeline driven by the MLP control unit;
//            MLP_RELU_EN selects ReLU on the written-back value
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mlp_mac_datapath
    import mlp_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NADDR_W-1:0] cu_in_addr,
    input  logic [NADDR_W-1:0] cu_out_addr,
    input  logic [WADDR_W-1:0] cu_w_addr,
    input  logic               cu_reset_acc,
    input  logic               cu_write,
    input  logic               cu_done,
    output logic [NADDR_W-1:0] nmem_raddr,
    input  logic [DATA_W-1:0]  nmem_rdata,
    output logic [WADDR_W-1:0] wmem_raddr,
    input  logic [DATA_W-1:0]  wmem_rdata,
    output logic               nmem_we,
    output logic [NADDR_W-1:0] nmem_waddr,
    output logic [DATA_W-1:0]  nmem_wdata,
    output logic [DATA_W-1:0]  result_o,
    output logic               done_o,
    output logic               raw_hazard
);

    logic        r_draining;
    logic        r_done;
    logic        r_hazard;
    logic        r_s1_v;
    logic        r_s2_v;
    logic        r_s3_v;
    logic        r_first;
    term_flags_t r_s1_f;
    term_flags_t r_s2_f;
    logic        r_s3_last;
    naddr_t      r_s3_waddr;
    prod_t       r_prod;
    acc_t        r_acc;
    data_t       w_rounded;
    logic        w_drain;
    logic        w_term;
    logic        w_hit;

    assign nmem_raddr = cu_in_addr;
    assign wmem_raddr = cu_w_addr;
    assign w_drain    = r_draining | cu_done;
    assign w_term     = ~w_drain;
    assign done_o     = r_done;
    assign raw_hazard = r_hazard;

    // Any in-flight write-back whose address this read would see stale
    always_comb begin
        w_hit = 1'b0;
        if (r_s1_v && r_s1_f.last && (r_s1_f.waddr == cu_in_addr)) w_hit = 1'b1;
        if (r_s2_v && r_s2_f.last && (r_s2_f.waddr == cu_in_addr)) w_hit = 1'b1;
        if (r_s3_v && r_s3_last   && (r_s3_waddr   == cu_in_addr)) w_hit = 1'b1;
        if (nmem_we && (nmem_waddr == cu_in_addr))                 w_hit = 1'b1;
    end

    mlp_round_sat u_round_sat (
        .acc    (r_acc),
        .result (w_rounded)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_draining <= 1'b0;
            r_done     <= 1'b0;
            r_hazard   <= 1'b0;
            r_s1_v     <= 1'b0;
            r_s2_v     <= 1'b0;
            r_s3_v     <= 1'b0;
            r_first    <= 1'b1;
            r_s1_f     <= '0;
            r_s2_f     <= '0;
            r_s3_last  <= 1'b0;
            r_s3_waddr <= '0;
            r_prod     <= '0;
            r_acc      <= '0;
            nmem_we    <= 1'b0;
            nmem_waddr <= '0;
            nmem_wdata <= '0;
            result_o   <= '0;
        end else begin
            // S1: flags ride alongside the synchronous RAM read
            r_s1_v       <= w_term;
            r_s1_f.last  <= cu_write;
            r_s1_f.clr   <= cu_reset_acc & ~cu_write;
            r_s1_f.waddr <= cu_out_addr;

            // S2: product of the returned operands
            r_s2_v <= r_s1_v;
            r_s2_f <= r_s1_f;
            r_prod <= prod_t'(data_t'(nmem_rdata)) * prod_t'(data_t'(wmem_rdata));

            // S3: accumulate, restarting right after a neuron's last term
            r_s3_v     <= r_s2_v;
            r_s3_last  <= r_s2_f.last;
            r_s3_waddr <= r_s2_f.waddr;
            if (r_s2_v) begin
                if (r_s2_f.clr) begin
                    r_acc <= '0;
                end else begin
                    r_acc <= (r_first ? acc_t'(0) : r_acc) + acc_t'(r_prod);
                end
                r_first <= r_s2_f.last;
            end

            // S4: write-back of the finished neuron
            nmem_we <= r_s3_v & r_s3_last;
            if (r_s3_v && r_s3_last) begin
                nmem_waddr <= r_s3_waddr;
                nmem_wdata <= w_rounded;
                result_o   <= w_rounded;
            end

            r_draining <= w_drain;
            r_done     <= r_done | (w_drain & ~r_s1_v & ~r_s2_v & ~r_s3_v);
            r_hazard   <= r_hazard | (w_term & w_hit);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mlp_mac_datapath.sv
// ============================================================================
// Module   : tb_mlp_mac_datapath
// Brief    : Randomised scoreboard bench for mlp_mac_datapath (MLP_RELU_EN aware)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mlp_mac_datapath;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] cu_in_addr = '0;
    logic [11:0] cu_out_addr = '0;
    logic [15:0] cu_w_addr = '0;
    logic        cu_reset_acc = 1'b1;
    logic        cu_write = 1'b0;
    logic        cu_done = 1'b0;
    logic [11:0] nmem_raddr;
    logic [15:0] nmem_rdata = '0;
    logic [15:0] wmem_raddr;
    logic [15:0] wmem_rdata = '0;
    logic        nmem_we;
    logic [11:0] nmem_waddr;
    logic [15:0] nmem_wdata;
    logic [15:0] result_o;
    logic        done_o;
    logic        raw_hazard;

    mlp_mac_datapath dut (
        .clk          (clk),
        .reset        (reset),
        .cu_in_addr   (cu_in_addr),
        .cu_out_addr  (cu_out_addr),
        .cu_w_addr    (cu_w_addr),
        .cu_reset_acc (cu_reset_acc),
        .cu_write     (cu_write),
        .cu_done      (cu_done),
        .nmem_raddr   (nmem_raddr),
        .nmem_rdata   (nmem_rdata),
        .wmem_raddr   (wmem_raddr),
        .wmem_rdata   (wmem_rdata),
        .nmem_we      (nmem_we),
        .nmem_waddr   (nmem_waddr),
        .nmem_wdata   (nmem_wdata),
        .result_o     (result_o),
        .done_o       (done_o),
        .raw_hazard   (raw_hazard)
    );

    always #5 clk = ~clk;

    // Read-only RAM models; the bench owns the contents
    logic [15:0] nmem [0:4095];
    logic [15:0] wmem [0:65535];
    always @(posedge clk) begin
        nmem_rdata <= nmem[nmem_raddr];
        wmem_rdata <= wmem[wmem_raddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] a;
        logic [15:0] d;
        int          c;
    } exp_t;

    exp_t   exp_q[$];
    longint model_sum = 0;
    int     n_tests = 0;
    int     n_fail = 0;
    int     last_we_cyc = -1;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Neuron value from the exact real-valued sum: floor(sum/2^8 + 1/2), clamped
    function automatic logic [15:0] ref_neuron(input longint s);
        longint q;
        q = s + 128;
        if (q >= 0) q = q / 256;
        else        q = -((-q + 255) / 256);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
`ifdef MLP_RELU_EN
        if (q < 0) q = 0;
`endif
        return q[15:0];
    endfunction

    function automatic logic [15:0] rand_val();
        int v;
        if ($urandom_range(0, 1) == 0) v = $urandom;
        else v = int'($urandom_range(0, 1023)) - 512;
        return v[15:0];
    endfunction

    task automatic drive_term(input logic [11:0] ia, input logic [15:0] wa, input logic [11:0] oa,
                              input bit clr, input bit last, input logic [15:0] nv,
                              input logic [15:0] wv);
        @(negedge clk);
        nmem[ia]     = nv;
        wmem[wa]     = wv;
        cu_in_addr   = ia;
        cu_w_addr    = wa;
        cu_out_addr  = oa;
        cu_reset_acc = clr;
        cu_write     = last;
        cu_done      = 1'b0;
        if (clr && !last) model_sum = 0;
        else model_sum += longint'($signed(nv)) * longint'($signed(wv));
        if (last) begin
            exp_q.push_back('{oa, ref_neuron(model_sum), cyc + 4});
            model_sum = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_term(12'h000, 16'h0000, 12'h000, 1'b1, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic neuron_const(input int n, input logic [15:0] nv, input logic [15:0] wv,
                                input logic [11:0] oa);
        for (int i = 0; i < n; i++)
            drive_term(12'(16 + i), 16'(32 + i), oa, 1'b0, i == n - 1, nv, wv);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        cu_reset_acc = 1'b1;
        cu_write     = 1'b0;
        cu_done      = 1'b0;
        model_sum    = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every write-back is matched against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!reset && nmem_we) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h, required no write (cycle %0d)",
                         nmem_waddr, nmem_wdata, cyc);
            end else begin
                e = exp_q.pop_front();
                check("waddr", longint'(nmem_waddr), longint'(e.a));
                check("wdata", longint'(nmem_wdata), longint'(e.d));
                check("we_cycle", longint'(cyc), longint'(e.c));
            end
            last_we_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int done_cyc;
        for (int i = 0; i < 4096; i++)  nmem[i] = '0;
        for (int i = 0; i < 65536; i++) wmem[i] = '0;

        do_reset();
        check("reset_we", longint'(nmem_we), 0);
        check("reset_result", longint'(result_o), 0);
        check("reset_done", longint'(done_o), 0);
        check("reset_hazard", longint'(raw_hazard), 0);

        // Directed neurons, issued back-to-back
        neuron_const(4, 16'h0100, 16'h0080, 12'h401);
        neuron_const(4, 16'h7FFF, 16'h7FFF, 12'hC01);
        neuron_const(4, 16'h8000, 16'h7FFF, 12'hC02);
        neuron_const(1, 16'h0100, 16'hFF00, 12'hC03);
        neuron_const(4, 16'h0100, 16'h0040, 12'hC04);
        neuron_const(1, 16'h0300, 16'h0100, 12'hC05);
        idle(2);

        // Random neurons, sometimes opened by a reset_mult_acc term
        for (int k = 0; k < 40; k++) begin
            int nt;
            nt = $urandom_range(1, 8);
            if ($urandom_range(0, 3) == 0)
                drive_term(12'($urandom_range(0, 1023)), 16'($urandom), 12'h000, 1'b1, 1'b0,
                           rand_val(), rand_val());
            for (int i = 0; i < nt; i++)
                drive_term(12'($urandom_range(0, 1023)), 16'($urandom),
                           12'($urandom_range(12'hC00, 12'hFFF)), 1'b0, i == nt - 1,
                           rand_val(), rand_val());
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(6);
        check("no_hazard_yet", longint'(raw_hazard), 0);

        // Read of an address whose write-back is still in flight
        neuron_const(2, 16'h0100, 16'h0100, 12'hC10);
        drive_term(12'hC10, 16'h0005, 12'hC11, 1'b0, 1'b0, 16'h0100, 16'h0100);
        drive_term(12'h020, 16'h0006, 12'hC11, 1'b0, 1'b1, 16'h0200, 16'h0100);
        idle(6);
        check("hazard_set", longint'(raw_hazard), 1);
        idle(2);
        check("hazard_sticky", longint'(raw_hazard), 1);

        // Reset after 2 of 4 terms: no write, flags cleared
        drive_term(12'h030, 16'h0030, 12'hC20, 1'b0, 1'b0, 16'h0100, 16'h0100);
        drive_term(12'h031, 16'h0031, 12'hC20, 1'b0, 1'b0, 16'h0100, 16'h0100);
        do_reset();
        check("midreset_hazard", longint'(raw_hazard), 0);
        check("midreset_result", longint'(result_o), 0);
        idle(6);
        check("midreset_no_we", longint'(nmem_we), 0);
        neuron_const(4, 16'h0100, 16'h0080, 12'h402);
        idle(1);

        // Done: final neuron then cu_done with junk that must be ignored
        neuron_const(4, 16'h0180, 16'h0100, 12'hC30);
        done_cyc = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done_o && done_cyc < 0) done_cyc = cyc;
            cu_done      = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            cu_write     = 1'b1;
            cu_reset_acc = 1'b0;
            cu_in_addr   = 12'hC30;
            cu_out_addr  = 12'hC31;
        end
        if (done_cyc < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got done_o=0 after 16 cycles, required done_o=1");
        end else begin
            check("done_cycle", longint'(done_cyc), longint'(last_we_cyc + 1));
        end
        check("done_sticky", longint'(done_o), 1);
        check("final_result", longint'(result_o), longint'(ref_neuron(longint'(16'h0180) * 256 * 4)));
        check("ignored_after_done_hazard", longint'(raw_hazard), 0);
        check("pending_writes", longint'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
